// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch path.
package cpu_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 24;
    localparam int OPC_W   = 4;
    localparam logic [OPC_W-1:0] HALT_OPC = 4'hF;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [INSTR_W-1:0] instr_t;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    function automatic logic [OPC_W-1:0] opcode(input instr_t instr);
        return instr[INSTR_W-1 -: OPC_W];
    endfunction

endpackage

// File: rtl/instruction_memory.sv
// Instruction store: zero-latency combinational read at PC, synchronous write port for loading.
// Backpressure: none; the read port is always available.
module instruction_memory
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   we_i,
    input  addr_t  waddr_i,
    input  instr_t wdata_i,
    input  addr_t  PC,
    output instr_t Instr
);

    instr_t mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign Instr = mem_q[PC];

endmodule

// File: rtl/fetch_unit.sv
// Sequential fetch: one instruction per cycle into a single output register, 1-cycle latency from PC.
// Backpressure: the register holds (and PC holds) while instr_valid && !instr_ready; redirect flushes it.
module fetch_unit
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    output addr_t  PC,
    input  instr_t Instr,
    output instr_t instr_out,
    output addr_t  instr_pc,
    output logic   instr_valid,
    input  logic   instr_ready,
    input  logic   redirect_valid,
    input  addr_t  redirect_target,
    output logic   halted
);

    fetch_state_t state_q, state_d;
    addr_t        pc_q, pc_d;
    instr_t       instr_q, instr_d;
    addr_t        ipc_q, ipc_d;
    logic         vld_q, vld_d;
    logic         slot_free;

    assign slot_free = !vld_q || instr_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= '0;
            instr_q <= '0;
            ipc_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        vld_d   = vld_q;

        if (redirect_valid) begin
            // Pending instruction is dropped even if decode is accepting it this cycle.
            pc_d    = redirect_target;
            vld_d   = 1'b0;
            state_d = FETCH;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (slot_free) begin
                        instr_d = Instr;
                        ipc_d   = pc_q;
                        vld_d   = 1'b1;
                        if (opcode(Instr) == HALT_OPC) begin
                            state_d = HALTED;
                        end else begin
                            pc_d = pc_q + 1'b1;
                        end
                    end
                end
                HALTED: begin
                    if (instr_ready) begin
                        vld_d = 1'b0;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    assign PC          = pc_q;
    assign instr_out   = instr_q;
    assign instr_pc    = ipc_q;
    assign instr_valid = vld_q;
    assign halted      = (state_q == HALTED);

endmodule
